exc_ctrl: RTL and testbench
===========================

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter EX_ENTRY, default 32'hbfc00380: exception/interrupt redirect target.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 ws_valid  input  1  a valid instruction is present in WB this cycle.
REQ-005 ws_ex  input  1  the WB instruction carries a synchronous exception (already qualified by ws_valid).
REQ-006 ws_eret  input  1  the WB instruction is ERET (already qualified by ws_valid).
REQ-007 cp0_epc  input  32  current CP0 EPC value.
REQ-008 cp0_status  input  32  CP0 Status: bit0 IE, bit1 EXL, bits15:8 IM.
REQ-009 cp0_cause  input  32  CP0 Cause: bits15:8 IP.
REQ-010 fs_allowin  input  1  fetch stage accepts the redirect this cycle.
REQ-011 int_take  output  1  combinational; tells WB/CP0 to record an interrupt (excode 5'h00) on the current WB instruction.
REQ-012 flush  output  1  registered one-cycle pulse that clears every pipeline stage.
REQ-013 redirect_valid  output  1  registered; redirect PC offered to fetch.
REQ-014 redirect_pc  output  32  registered redirect target.
REQ-015 busy  output  1  high whenever the FSM is not IDLE.
REQ-016 ex_cnt  output  8  saturating count of exceptions plus interrupts taken (debug).

Function
REQ-017 int_pend SHALL equal IE & ~EXL & |(IM & IP).
REQ-018 int_take SHALL equal int_pend & ws_valid & ~ws_ex & state==IDLE.
REQ-019 The event classes in IDLE, in decreasing priority, SHALL be: EXC (ws_ex | int_take), then ERET (ws_eret & ~ws_ex & ~int_take).
REQ-020 FSM states SHALL be IDLE and REDIR.
REQ-021 IDLE with EXC at cycle N: in cycle N+1 flush=1, redirect_valid=1, redirect_pc=EX_ENTRY, state=REDIR.
REQ-022 IDLE with ERET at cycle N: in cycle N+1 flush=1, redirect_valid=1, redirect_pc=cp0_epc sampled at cycle N, state=REDIR.
REQ-023 flush SHALL be high for exactly one cycle per accepted event, even if REDIR lasts longer.
REQ-024 In REDIR, redirect_valid and redirect_pc SHALL hold stable until a cycle with fs_allowin=1; the next cycle SHALL have redirect_valid=0 and state=IDLE.
REQ-025 Minimum event-to-event spacing SHALL be 2 cycles (event, REDIR with fs_allowin=1, then IDLE can accept the next event).
REQ-026 In REDIR, ws_ex, ws_eret and int_pend SHALL be ignored, and int_take SHALL be 0.
REQ-027 ex_cnt SHALL increment by 1 on each EXC event accepted in IDLE, SHALL saturate at 8'hff, and SHALL NOT count ERET events.
REQ-028 ws_ex and ws_eret high in the same cycle SHALL be treated as EXC.
REQ-029 An interrupt pending while ws_valid=0 SHALL NOT be taken; it SHALL be taken on the first later IDLE cycle with ws_valid=1.
REQ-030 busy SHALL equal (state==REDIR).

Reset
REQ-031 While resetn=0 (asynchronous): state=IDLE, flush=0, redirect_valid=0, redirect_pc=32'h0, ex_cnt=8'h0.
REQ-032 Reset asserted in REDIR SHALL abort the redirect immediately, without waiting for a clock edge.
REQ-033 After resetn deasserts, events SHALL be accepted from the first rising edge.

Verification
REQ-034 ws_ex=1 at cycle N, fs_allowin=1 -> N+1: flush=1, redirect_valid=1, redirect_pc=32'hbfc00380, ex_cnt=1; N+2: IDLE, redirect_valid=0.
REQ-035 ws_eret=1 with cp0_epc=32'hbfc01234 at N, cp0_epc changed to 0 at N+1, fs_allowin=0 for 3 cycles -> redirect_pc holds 32'hbfc01234 for cycles N+1..N+4, flush high only at N+1, ex_cnt unchanged.
REQ-036 Status=32'h0000_0401 (IE=1, IM2=1), Cause IP2=1, ws_valid=1 -> int_take=1 the same cycle, redirect_pc=EX_ENTRY the next cycle; repeat with EXL=1 (Status=32'h0000_0403) -> int_take=0, no flush.
REQ-037 ws_ex=1 and ws_eret=1 together with cp0_epc=32'h1000 -> redirect_pc=32'hbfc00380, ex_cnt increments.
REQ-038 ws_ex pulsed during REDIR -> no second flush, ex_cnt unchanged; 256 EXC events -> ex_cnt=8'hff.
REQ-039 resetn driven low mid-REDIR between clock edges -> redirect_valid=0 and busy=0 immediately; ex_cnt=0.

Source files
------------

// File: rtl/exc_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// exc_ctrl
// Exception / interrupt / ERET redirect controller at the write-back stage.
// An accepted event produces a one-cycle pipeline flush and a redirect PC.
// The redirect is held until fetch accepts it, then the controller returns
// to IDLE and can accept the next event.
//
// Ports:
//   clk            in   clock, all state on rising edge
//   resetn         in   asynchronous active-low reset
//   ws_valid       in   valid instruction in WB
//   ws_ex          in   WB instruction has a synchronous exception
//   ws_eret        in   WB instruction is ERET
//   cp0_epc        in   [31:0] CP0 EPC
//   cp0_status     in   [31:0] CP0 Status (IE bit0, EXL bit1, IM 15:8)
//   cp0_cause      in   [31:0] CP0 Cause (IP 15:8)
//   fs_allowin     in   fetch accepts the redirect this cycle
//   int_take       out  combinational: record an interrupt on the WB instr
//   flush          out  registered one-cycle flush pulse
//   redirect_valid out  registered redirect request
//   redirect_pc    out  [31:0] registered redirect target
//   busy           out  controller is in REDIR
//   ex_cnt         out  [7:0] saturating count of taken exceptions/interrupts
// -----------------------------------------------------------------------------
module exc_ctrl #(
  parameter logic [31:0] EX_ENTRY = 32'hbfc00380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_valid,
  input  logic        ws_ex,
  input  logic        ws_eret,
  input  logic [31:0] cp0_epc,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic        fs_allowin,
  output logic        int_take,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic [7:0]  ex_cnt
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_REDIR = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_flush;
  logic        r_redirect_valid;
  logic [31:0] r_redirect_pc;
  logic [7:0]  r_ex_cnt;

  logic        w_flush_nxt;
  logic        w_redirect_valid_nxt;
  logic [31:0] w_redirect_pc_nxt;
  logic [7:0]  w_ex_cnt_nxt;

  logic        w_idle;
  logic        w_int_pend;
  logic        w_int_take;
  logic        w_exc;
  logic        w_eret;
  logic        w_unused_bits;

  // Interrupt pending: globally enabled, not already in exception level,
  // and at least one unmasked pending line.
  function automatic logic f_int_pend(input logic ie, input logic exl,
                                      input logic [7:0] im, input logic [7:0] ip);
    return ie & ~exl & (|(im & ip));
  endfunction

  assign w_unused_bits = ^{cp0_status[31:16], cp0_status[7:2],
                           cp0_cause[31:16], cp0_cause[7:0]};

  assign w_idle     = (r_state == S_IDLE);
  assign w_int_pend = f_int_pend(cp0_status[0], cp0_status[1],
                                 cp0_status[15:8], cp0_cause[15:8]);
  // An interrupt is only attached to a real instruction that is not already
  // faulting; a faulting instruction reports its own exception instead.
  assign w_int_take = w_int_pend & ws_valid & ~ws_ex & w_idle;
  assign w_exc      = w_idle & (ws_ex | w_int_take);
  assign w_eret     = w_idle & ws_eret & ~ws_ex & ~w_int_take;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_exc || w_eret) begin
          w_state_nxt = S_REDIR;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REDIR: begin
        if (fs_allowin) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_REDIR;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_flush_nxt          = 1'b0;
    w_redirect_valid_nxt = 1'b0;
    w_redirect_pc_nxt    = r_redirect_pc;
    w_ex_cnt_nxt         = r_ex_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_exc) begin
          w_flush_nxt          = 1'b1;
          w_redirect_valid_nxt = 1'b1;
          w_redirect_pc_nxt    = EX_ENTRY;
          if (r_ex_cnt != 8'hff) begin
            w_ex_cnt_nxt = r_ex_cnt + 8'h01;
          end else begin
            w_ex_cnt_nxt = r_ex_cnt;
          end
        end else if (w_eret) begin
          w_flush_nxt          = 1'b1;
          w_redirect_valid_nxt = 1'b1;
          w_redirect_pc_nxt    = cp0_epc;
        end else begin
          w_flush_nxt          = 1'b0;
          w_redirect_valid_nxt = 1'b0;
        end
      end
      S_REDIR: begin
        // Flush already went out on entry; only the request is held.
        w_flush_nxt          = 1'b0;
        w_redirect_valid_nxt = ~fs_allowin;
      end
      default: begin
        w_flush_nxt          = 1'b0;
        w_redirect_valid_nxt = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'h0000_0000;
      r_ex_cnt         <= 8'h00;
    end else begin
      r_flush          <= w_flush_nxt;
      r_redirect_valid <= w_redirect_valid_nxt;
      r_redirect_pc    <= w_redirect_pc_nxt;
      r_ex_cnt         <= w_ex_cnt_nxt;
    end
  end

  assign int_take       = w_int_take;
  assign flush          = r_flush;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign busy           = (r_state == S_REDIR);
  assign ex_cnt         = r_ex_cnt;

endmodule

// File: tb/tb_exc_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_exc_ctrl
// Randomized and directed stimulus for exc_ctrl, checked every cycle against
// an event-level reference model, plus literal expectations for key cases.
// -----------------------------------------------------------------------------
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_valid, ws_ex, ws_eret, fs_allowin;
  logic [31:0] cp0_epc, cp0_status, cp0_cause;
  logic        int_take, flush, redirect_valid, busy;
  logic [31:0] redirect_pc;
  logic [7:0]  ex_cnt;

  always #5 clk = ~clk;

  exc_ctrl #(.EX_ENTRY(32'hbfc00380)) dut (
    .clk(clk), .resetn(resetn), .ws_valid(ws_valid), .ws_ex(ws_ex),
    .ws_eret(ws_eret), .cp0_epc(cp0_epc), .cp0_status(cp0_status),
    .cp0_cause(cp0_cause), .fs_allowin(fs_allowin), .int_take(int_take),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .ex_cnt(ex_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: "is a redirect outstanding", what it points at,
  // whether this cycle is the first cycle of it, and the event tally.
  bit          m_busy;
  bit          m_flush;
  logic [31:0] m_pc;
  int          m_cnt;
  int          lit_it = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit irq_pending();
    return cp0_status[0] && !cp0_status[1] && ((cp0_status[15:8] & cp0_cause[15:8]) != 8'h00);
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_flush = 1'b0;
    m_pc    = 32'h0;
    m_cnt   = 0;
  endtask

  task automatic drive(input logic v, input logic ex, input logic er, input logic [31:0] epc,
                       input logic [31:0] st, input logic [31:0] ca, input logic allow);
    ws_valid = v; ws_ex = ex; ws_eret = er; cp0_epc = epc;
    cp0_status = st; cp0_cause = ca; fs_allowin = allow;
  endtask

  // One clock cycle: entered at posedge+1 with inputs already driven.
  task automatic step();
    bit exp_it;
    #3;
    exp_it = !m_busy && irq_pending() && ws_valid && !ws_ex;
    chk("int_take", {31'h0, int_take}, {31'h0, exp_it});
    if (lit_it >= 0) chk("int_take_lit", {31'h0, int_take}, lit_it[31:0]);
    lit_it = -1;
    @(posedge clk);
    if (!m_busy) begin
      if (ws_ex || exp_it) begin
        m_busy = 1'b1; m_flush = 1'b1; m_pc = 32'hbfc00380;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end else if (ws_eret) begin
        m_busy = 1'b1; m_flush = 1'b1; m_pc = cp0_epc;
      end else begin
        m_flush = 1'b0;
      end
    end else begin
      m_flush = 1'b0;
      if (fs_allowin) m_busy = 1'b0;
    end
    #1;
    chk("flush", {31'h0, flush}, {31'h0, m_flush});
    chk("redirect_valid", {31'h0, redirect_valid}, {31'h0, m_busy});
    chk("busy", {31'h0, busy}, {31'h0, m_busy});
    chk("ex_cnt", {24'h0, ex_cnt}, m_cnt[31:0]);
    if (m_busy) chk("redirect_pc", redirect_pc, m_pc);
  endtask

  task automatic idle_step(input logic allow);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, allow);
    step();
  endtask

  initial begin
    logic [31:0] st, ca;
    resetn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    model_reset();
    #12;
    chk("rst_flush", {31'h0, flush}, 32'h0);
    chk("rst_rv", {31'h0, redirect_valid}, 32'h0);
    chk("rst_pc", redirect_pc, 32'h0);
    chk("rst_cnt", {24'h0, ex_cnt}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Plain exception
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    step();
    chk("exc_flush", {31'h0, flush}, 32'h1);
    chk("exc_pc", redirect_pc, 32'hbfc00380);
    chk("exc_cnt", {24'h0, ex_cnt}, 32'h1);
    idle_step(1'b1);
    chk("exc_ret_rv", {31'h0, redirect_valid}, 32'h0);
    chk("exc_ret_busy", {31'h0, busy}, 32'h0);

    // Exception and ERET together: exception wins
    drive(1'b1, 1'b1, 1'b1, 32'h1000, 32'h0, 32'h0, 1'b1);
    step();
    chk("both_pc", redirect_pc, 32'hbfc00380);
    chk("both_cnt", {24'h0, ex_cnt}, 32'h2);
    idle_step(1'b1);

    // Interrupt taken, then blocked by EXL
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0401, 32'h0000_0400, 1'b1);
    lit_it = 1;
    step();
    chk("int_pc", redirect_pc, 32'hbfc00380);
    chk("int_cnt", {24'h0, ex_cnt}, 32'h3);
    idle_step(1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0403, 32'h0000_0400, 1'b1);
    lit_it = 0;
    step();
    chk("exl_flush", {31'h0, flush}, 32'h0);

    // Pending interrupt waits for a valid instruction
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0401, 32'h0000_0400, 1'b1);
    lit_it = 0;
    step();
    chk("noval_flush", {31'h0, flush}, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0401, 32'h0000_0400, 1'b1);
    lit_it = 1;
    step();
    chk("late_int_cnt", {24'h0, ex_cnt}, 32'h4);
    idle_step(1'b1);

    // ERET with EPC changing and fetch stalled
    drive(1'b1, 1'b0, 1'b1, 32'hbfc01234, 32'h0, 32'h0, 1'b0);
    step();
    chk("eret_flush", {31'h0, flush}, 32'h1);
    chk("eret_pc", redirect_pc, 32'hbfc01234);
    for (int i = 0; i < 3; i++) begin
      idle_step(1'b0);
      chk("eret_hold_pc", redirect_pc, 32'hbfc01234);
      chk("eret_hold_flush", {31'h0, flush}, 32'h0);
    end
    chk("eret_cnt", {24'h0, ex_cnt}, 32'h4);
    idle_step(1'b1);
    chk("eret_done_rv", {31'h0, redirect_valid}, 32'h0);

    // Exception during REDIR is ignored
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    chk("redir_ex_flush", {31'h0, flush}, 32'h0);
    chk("redir_ex_cnt", {24'h0, ex_cnt}, 32'h5);
    idle_step(1'b1);

    // Saturation
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      step();
      idle_step(1'b1);
    end
    chk("sat_cnt", {24'h0, ex_cnt}, 32'hff);

    // Asynchronous reset in the middle of a redirect
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_rv", {31'h0, redirect_valid}, 32'h0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_cnt", {24'h0, ex_cnt}, 32'h0);
    chk("arst_flush", {31'h0, flush}, 32'h0);
    model_reset();
    @(posedge clk); #1;
    resetn = 1'b1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      st = {16'h0, ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, 6'h0,
            1'($urandom_range(0, 3) == 0), 1'($urandom)};
      ca = {16'h0, 8'($urandom), 8'h0};
      ws_valid = 1'($urandom_range(0, 3) != 0);
      ws_ex    = ws_valid && ($urandom_range(0, 5) == 0);
      ws_eret  = ws_valid && ($urandom_range(0, 4) == 0);
      drive(ws_valid, ws_ex, ws_eret, $urandom, st, ca, 1'($urandom));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
